// File: rtl/spec_pkg.sv
// Shared constants and data types for the spectrum power accumulator.
// The default sizes match the FFT stream this block normally sits behind.
package spec_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_NFFT    = 32;
  localparam int DEF_ACC_LEN = 4;
  localparam int DEF_ACC_W   = 40;
  localparam int BIN_W       = $clog2(DEF_NFFT);

  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] im;
    logic signed [DEF_WIDTH-1:0] re;
  } cx_t;

  typedef logic [2*DEF_WIDTH:0] power_t;
  typedef logic [DEF_ACC_W-1:0] acc_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port and one registered read port with a read enable.
// The read data holds its value while the read enable is low.
module sdp_ram #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 40,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/spectrum_power_acc.sv
// Per-bin |X|^2 integrator over ACC_LEN consecutive FFT spectra.
// Five-stage pipeline frozen as a whole by back-pressure from the output.
module spectrum_power_acc
  import spec_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NFFT    = DEF_NFFT,
  parameter int ACC_LEN = DEF_ACC_LEN,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [2*WIDTH-1:0] s_axis_tdata,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  output logic               s_axis_tready,
  output logic [ACC_W-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready,
  output logic               tlast_unexpected,
  output logic               tlast_missing,
  output logic               overflow
);

  localparam int ADDR_W = $clog2(NFFT);
  localparam int FRM_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam int PW     = 2*WIDTH + 1;

  logic              ce;
  logic              accept;
  logic [ADDR_W-1:0] bin_cnt;
  logic [FRM_W-1:0]  frm_cnt;
  logic              bin_last;
  logic              frm_last;

  assign ce            = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = ce;
  assign accept        = s_axis_tvalid && ce;
  assign bin_last      = (bin_cnt == ADDR_W'(NFFT-1));
  assign frm_last      = (frm_cnt == FRM_W'(ACC_LEN-1));

  // Counters are free-running on accepted beats; tlast never realigns them.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bin_cnt <= '0;
      frm_cnt <= '0;
    end else if (accept) begin
      bin_cnt <= bin_cnt + 1'b1;
      if (bin_last) frm_cnt <= frm_last ? '0 : frm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tlast_unexpected <= 1'b0;
      tlast_missing    <= 1'b0;
    end else begin
      tlast_unexpected <= accept && s_axis_tlast && !bin_last;
      tlast_missing    <= accept && !s_axis_tlast && bin_last;
    end
  end

  logic                     s0_valid, s1_valid, s2_valid, s3_valid;
  logic signed [WIDTH-1:0]  s0_re, s0_im;
  logic [ADDR_W-1:0]        s0_bin, s1_bin, s2_bin;
  logic                     s0_first, s1_first, s2_first;
  logic                     s0_out, s1_out, s2_out, s3_out;
  logic                     s3_last_bin;
  logic [2*WIDTH-1:0]       s1_rr, s1_ii;
  logic [PW-1:0]            s2_p;
  logic [ACC_W-1:0]         s3_sum;
  logic signed [2*WIDTH-1:0] rr_full, ii_full;
  logic [ACC_W-1:0]         ram_q;
  logic [ACC_W-1:0]         base;
  logic [ACC_W:0]           sum_ext;
  logic                     sat;
  logic [ACC_W-1:0]         sum;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (ce) begin
      s0_valid <= accept;
      s1_valid <= s0_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  assign rr_full = s0_re * s0_re;
  assign ii_full = s0_im * s0_im;

  always_ff @(posedge clk) begin
    if (ce) begin
      s0_re    <= $signed(s_axis_tdata[WIDTH-1:0]);
      s0_im    <= $signed(s_axis_tdata[2*WIDTH-1:WIDTH]);
      s0_bin   <= bin_cnt;
      s0_first <= (frm_cnt == '0);
      s0_out   <= frm_last;
      s1_rr    <= $unsigned(rr_full);
      s1_ii    <= $unsigned(ii_full);
      s1_bin   <= s0_bin;
      s1_first <= s0_first;
      s1_out   <= s0_out;
      s2_p     <= {1'b0, s1_rr} + {1'b0, s1_ii};
      s2_bin   <= s1_bin;
      s2_first <= s1_first;
      s2_out   <= s1_out;
      s3_sum   <= sum;
      s3_last_bin <= (s2_bin == ADDR_W'(NFFT-1));
      s3_out   <= s2_out;
    end
  end

  // The first frame of an integration ignores stale RAM contents, so no clear pass is needed.
  assign base    = s2_first ? '0 : ram_q;
  assign sum_ext = {1'b0, base} + (ACC_W+1)'(s2_p);
  assign sat     = sum_ext[ACC_W];
  assign sum     = sat ? '1 : sum_ext[ACC_W-1:0];

  sdp_ram #(
    .DEPTH (NFFT),
    .DATA_W(ACC_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (ce && s2_valid),
    .wr_addr(s2_bin),
    .wr_data(sum),
    .rd_en  (ce && s1_valid),
    .rd_addr(s1_bin),
    .rd_data(ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (ce && s2_valid && sat) begin
      overflow <= 1'b1;
    end
  end

  // Only the final frame of each integration reaches the output stream.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (ce) begin
      m_axis_tvalid <= s3_valid && s3_out;
      m_axis_tdata  <= s3_sum;
      m_axis_tlast  <= s3_valid && s3_out && s3_last_bin;
    end
  end

endmodule
